banner_ctrl: RTL and testbench
==============================

// Module: banner_ctrl
// PURPOSE
//  Front-end controller for rotating_banner on the 7-seg board.
//  - Debounces two raw pushbuttons: RUN (pause/resume) and DIR (direction).
//  - Drives the banner's en as a one-cycle scroll-step pulse at a fixed rate.
//  - Drives the banner's dir as a level that toggles on each DIR press.
// PARAMETERS
//  DB_CYCLES    2_000_000   stable cycles required to accept a button edge (20 ms @100 MHz); >=2
//  TICK_CYCLES  25_000_000  clk cycles between scroll-step pulses (0.25 s @100 MHz); >=2
//  INIT_DIR     1           dir value after reset (1 = scroll right)
//  INIT_RUN     0           running value after reset (0 = paused)
// PORTS
//  clk      in   1  system clock, 100 MHz, rising edge
//  reset    in   1  asynchronous, active-low (0 = reset)
//  btn_run  in   1  raw RUN button, asynchronous to clk, bouncy, 1 = pressed
//  btn_dir  in   1  raw DIR button, asynchronous to clk, bouncy, 1 = pressed
//  en       out  1  one-cycle scroll-step pulse -> rotating_banner.en
//  dir      out  1  scroll direction level -> rotating_banner.dir
//  running  out  1  1 = scrolling active (status LED)
// BEHAVIOUR
//  Reset (reset==0, takes effect immediately, no clk needed):
//  - en=0, dir=INIT_DIR, running=INIT_RUN.
//  - Synchronizers, debouncer states and all counters cleared.
//  Synchronizer: each button goes through its own 2-FF chain; only the 2nd FF output (s) is used.
//  Debouncer FSM (one per button), count register cnt of width $clog2(DB_CYCLES):
//  - IDLE: s==1 -> WAIT_PRESS, cnt=0.
//  - WAIT_PRESS: s==0 -> IDLE. s==1 and cnt==DB_CYCLES-1 -> PRESSED, press pulse=1 for 1 cycle. Else cnt++.
//  - PRESSED: s==0 -> WAIT_RELEASE, cnt=0.
//  - WAIT_RELEASE: s==1 -> PRESSED. s==0 and cnt==DB_CYCLES-1 -> IDLE. Else cnt++.
//  - Exactly one press pulse per accepted press; holding the button never repeats it.
//  - A glitch shorter than DB_CYCLES aborts back to the prior stable state.
//  Latency:
//  - Raw button first sampled high at edge 1 and held stable.
//  - Press pulse is registered at edge DB_CYCLES+3.
//  - running/dir toggle at edge DB_CYCLES+4.
//  Toggles:
//  - running <= ~running on a RUN press.
//  - dir <= ~dir on a DIR press.
//  - Simultaneous RUN and DIR presses both apply on the same edge.
//  Scroll tick, counter tcnt of width $clog2(TICK_CYCLES):
//  - running==0: tcnt held at 0, en=0.
//  - running==1: tcnt counts 0..TICK_CYCLES-1 and wraps to 0.
//  - en is registered, and is 1 for exactly the cycle after tcnt==TICK_CYCLES-1.
//  - Consequence: the first en comes TICK_CYCLES+1 edges after running rises; en period = TICK_CYCLES.
//  - Pause clears tcnt, so after resume the full period restarts and no partial step occurs.
//  - A DIR toggle does not disturb tcnt or en timing.
//  - A pause on the same edge that tcnt wraps: the en already registered still fires; no further en follows.
//  Reset asserted mid-debounce or mid-tick: all state returns to the reset values; no pending pulse survives.
//  Outputs are all registered; no combinational path from btn_* to outputs.
// TESTING (bench params: DB_CYCLES=4, TICK_CYCLES=8, INIT_DIR=1, INIT_RUN=0)
//  1. Reset: reset=0 asynchronously mid-run -> en=0, dir=1, running=0 within the same time step; stays so while reset=0.
//  2. Clean RUN press, btn_run=1 for 20 cycles:
//     - running=1 at edge 8.
//     - en pulses 1 cycle wide, first at edge 17, then every 8 cycles.
//     - Exactly one toggle occurs.
//  3. Bounce, btn_run pattern 1,1,0,1,1,0,1 then steady 1 -> no toggle during the pattern; exactly one toggle after 4 stable synced cycles.
//  4. DIR press held 50 cycles -> dir 1->0 once. Release for 10 cycles, press again -> dir 0->1. en period unchanged at 8.
//  5. Pause/resume:
//     - RUN press while running -> running=0, no en afterwards.
//     - Second RUN press -> running=1; first en exactly 9 edges after running rises.
//  6. btn_run and btn_dir rise on the same cycle -> running and dir toggle on the same edge. Reset pulse mid-WAIT_PRESS -> no toggle.

Source files
------------

// File: rtl/banner_ctrl.sv
// Front-end for rotating_banner: debounces RUN/DIR buttons, generates the scroll-step pulse, holds direction.
// Latency: button stable at edge 1 -> press pulse at edge DB_CYCLES+3 -> running/dir toggle at edge DB_CYCLES+4.
// Backpressure: none; en is a fire-and-forget one-cycle strobe, outputs are all registered.

module banner_debounce #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_nxt;
    logic [1:0]    sync_q;
    logic          s;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
            state  <= IDLE;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            press  <= press_nxt;
        end
    end

    // Any sample that disagrees with the pending level aborts back to the last stable state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

module banner_ctrl #(
    parameter int   DB_CYCLES   = 2_000_000,
    parameter int   TICK_CYCLES = 25_000_000,
    parameter logic INIT_DIR    = 1'b1,
    parameter logic INIT_RUN    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_dir,
    output logic en,
    output logic dir,
    output logic running
);
    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_CYCLES - 1);

    logic          run_press;
    logic          dir_press;
    logic          run_d;
    logic [TW-1:0] tcnt;

    banner_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run),
        .press (run_press)
    );

    banner_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_dir),
        .press (dir_press)
    );

    // The tick counter is armed one cycle after running rises, so the first step lands
    // TICK_CYCLES+1 edges after resume; a pause clears it so no partial period carries over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= INIT_RUN;
            dir     <= INIT_DIR;
            en      <= 1'b0;
            run_d   <= 1'b0;
            tcnt    <= '0;
        end else begin
            running <= running ^ run_press;
            dir     <= dir ^ dir_press;
            run_d   <= running;
            en      <= running && run_d && (tcnt == TCNT_MAX);
            if (!running || !run_d) begin
                tcnt <= '0;
            end else if (tcnt == TCNT_MAX) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_banner_ctrl.sv
// Randomized bench for banner_ctrl: an event-level reference model feeds a scoreboard queue,
// and an independent monitor matches every en pulse and running/dir change against it.

module tb_banner_ctrl;
    localparam int DB = 4;
    localparam int TK = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_run = 1'b0;
    logic btn_dir = 1'b0;
    logic en, dir, running;

    banner_ctrl #(
        .DB_CYCLES   (DB),
        .TICK_CYCLES (TK),
        .INIT_DIR    (1'b1),
        .INIT_RUN    (1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_run (btn_run),
        .btn_dir (btn_dir),
        .en      (en),
        .dir     (dir),
        .running (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   kind;   // 0 = en pulse, 1 = running change, 2 = dir change
        int   edge_n;
        logic val;
    } ev_t;

    ev_t  sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model: raw button history per clock edge, stable button levels, output levels.
    logic hr[$];
    logic hd[$];
    logic lr, ld, pr, pd, mrun, mdir;
    int   rise_edge;

    function automatic bit window_all(input logic h[$], input logic v);
        // A level change is accepted once DB+1 consecutive synchronized samples disagree with it.
        for (int i = 0; i <= DB; i++) begin
            if (h[i] !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic reset_model();
        hr.delete();
        hd.delete();
        for (int i = 0; i < DB + 3; i++) begin
            hr.push_back(1'b0);
            hd.push_back(1'b0);
        end
        lr = 1'b0;
        ld = 1'b0;
        pr = 1'b0;
        pd = 1'b0;
        mrun = 1'b0;
        mdir = 1'b1;
        rise_edge = 0;
    endtask

    task automatic model_step();
        hr.push_back(btn_run);
        void'(hr.pop_front());
        hd.push_back(btn_dir);
        void'(hd.pop_front());
        if (mrun && cyc > rise_edge + 1 && ((cyc - rise_edge - 1) % TK) == 0)
            sb.push_back('{0, cyc, 1'b1});
        if (pr) begin
            mrun = !mrun;
            if (mrun) rise_edge = cyc;
            sb.push_back('{1, cyc, mrun});
        end
        if (pd) begin
            mdir = !mdir;
            sb.push_back('{2, cyc, mdir});
        end
        pr = 1'b0;
        pd = 1'b0;
        if (window_all(hr, !lr)) begin
            lr = !lr;
            pr = lr;
        end
        if (window_all(hd, !ld)) begin
            ld = !ld;
            pd = ld;
        end
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) reset_model();
            else model_step();
        end
    end

    // Monitor: decoupled from stimulus, pops whatever the model expects at this edge.
    logic prun, pdir;
    initial begin
        prun = 1'b0;
        pdir = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prun = running;
                pdir = dir;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    int   idx;
                    logic seen, val, exp_val;
                    string nm;
                    idx = -1;
                    exp_val = 1'b0;
                    case (k)
                        0:       begin seen = (en === 1'b1);      val = en;      nm = "en_pulse"; end
                        1:       begin seen = (running !== prun); val = running; nm = "running_toggle"; end
                        default: begin seen = (dir !== pdir);     val = dir;     nm = "dir_toggle"; end
                    endcase
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].kind == k && sb[i].edge_n == cyc) idx = i;
                    end
                    if (idx >= 0) exp_val = sb[idx].val;
                    if (idx >= 0 || seen) begin
                        n_chk++;
                        if ((idx >= 0) != seen || (seen && val !== exp_val)) begin
                            n_fail++;
                            $display("FAIL %s at edge %0d: dut event=%0b value=%0b, model event=%0b value=%0b",
                                     nm, cyc, seen, val, (idx >= 0), exp_val);
                        end
                        if (idx >= 0) sb.delete(idx);
                    end
                end
                prun = running;
                pdir = dir;
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_run(input int hold, input int gap);
        @(negedge clk);
        btn_run = 1'b1;
        idle(hold);
        btn_run = 1'b0;
        idle(gap);
    endtask

    initial begin
        logic pat [7];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state held while reset is low
        idle(3);
        chk("reset_en", en, 1'b0);
        chk("reset_dir", dir, 1'b1);
        chk("reset_running", running, 1'b0);
        reset = 1'b1;
        idle(3);

        // Clean RUN press: toggle at edge 8, first en at edge 17
        @(negedge clk);
        btn_run = 1'b1;
        idle(7);
        chk("run_before_edge8", running, 1'b0);
        idle(1);
        chk("run_at_edge8", running, 1'b1);
        idle(8);
        chk("en_before_edge17", en, 1'b0);
        idle(1);
        chk("en_at_edge17", en, 1'b1);
        idle(1);
        chk("en_after_edge17", en, 1'b0);
        idle(2);
        btn_run = 1'b0;
        idle(30);

        // Bouncy RUN press (pauses)
        for (int i = 0; i < 7; i++) begin
            btn_run = pat[i];
            idle(1);
        end
        idle(12);
        btn_run = 1'b0;
        idle(20);
        chk("bounce_paused", running, 1'b0);

        // DIR press held 50, released, pressed again
        @(negedge clk);
        btn_dir = 1'b1;
        idle(50);
        chk("dir_first_press", dir, 1'b0);
        btn_dir = 1'b0;
        idle(10);
        btn_dir = 1'b1;
        idle(20);
        chk("dir_second_press", dir, 1'b1);
        btn_dir = 1'b0;
        idle(20);

        // Resume, pause, resume
        press_run(10, 40);
        press_run(10, 30);
        chk("paused_no_en", en, 1'b0);
        press_run(10, 40);

        // Simultaneous RUN and DIR
        @(negedge clk);
        btn_run = 1'b1;
        btn_dir = 1'b1;
        idle(10);
        btn_run = 1'b0;
        btn_dir = 1'b0;
        idle(20);

        // Reset pulse while RUN debounce is pending
        btn_run = 1'b1;
        idle(4);
        reset = 1'b0;
        idle(2);
        btn_run = 1'b0;
        reset = 1'b1;
        idle(20);
        chk("reset_mid_wait_running", running, mrun);
        chk("reset_mid_wait_dir", dir, mdir);

        // Random bouncy activity
        for (int i = 0; i < 60; i++) begin
            btn_run = 1'($urandom_range(0, 1));
            btn_dir = 1'($urandom_range(0, 1));
            idle($urandom_range(1, 12));
        end
        btn_run = 1'b0;
        btn_dir = 1'b0;
        idle(20);

        // Asynchronous reset while scrolling
        if (!mrun) press_run(10, 20);
        idle(5);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_en", en, 1'b0);
        chk("async_reset_dir", dir, 1'b1);
        chk("async_reset_running", running, 1'b0);
        idle(3);
        chk("reset_hold_running", running, 1'b0);
        chk("reset_hold_en", en, 1'b0);
        reset = 1'b1;
        idle(30);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: %0d expected events never seen, required 0", sb.size());
        end
        chk("final_running", running, mrun);
        chk("final_dir", dir, mdir);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
